// File: rtl/mem_burst_master_if.sv
// Command, read-response and memory-port signals of mem_burst_master.
// master = the burst engine, slave = the command source / consumer / memory.
interface mem_burst_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic       cmd_incr;
  logic [6:0] cmd_addr;
  logic [3:0] cmd_len;
  logic [7:0] cmd_data;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_last;
  logic       done;

  logic       mem_ren;
  logic       mem_wen;
  logic [6:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;

  modport master (
    input  cmd_valid, cmd_write, cmd_incr, cmd_addr, cmd_len, cmd_data,
    output cmd_ready,
    input  rsp_ready,
    output rsp_valid, rsp_data, rsp_last, done,
    output mem_ren, mem_wen, mem_addr, mem_din,
    input  mem_dout
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_incr, cmd_addr, cmd_len, cmd_data,
    input  cmd_ready,
    output rsp_ready,
    input  rsp_valid, rsp_data, rsp_last, done,
    input  mem_ren, mem_wen, mem_addr, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/mem_burst_master.sv
// Burst engine for a 128x8 memory: pattern-fill writes at one beat per cycle,
// reads at three cycles per beat through a valid/ready response port.
module mem_burst_master (
  input  logic                  clk,
  input  logic                  rst,
  mem_burst_master_if.master    bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    RD_HOLD  = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t     state_reg, state_next;
  logic [6:0] addr_reg, addr_next;
  logic [7:0] data_reg, data_next;
  logic [3:0] len_reg, len_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       incr_reg, incr_next;
  logic [7:0] rsp_data_reg, rsp_data_next;
  logic       last_beat;

  assign last_beat = (cnt_reg == len_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      data_reg     <= '0;
      len_reg      <= '0;
      cnt_reg      <= '0;
      incr_reg     <= 1'b0;
      rsp_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      data_reg     <= data_next;
      len_reg      <= len_next;
      cnt_reg      <= cnt_next;
      incr_reg     <= incr_next;
      rsp_data_reg <= rsp_data_next;
    end
  end

  // Next state and datapath; 7/8-bit adders give the required address/data wrap.
  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    data_next     = data_reg;
    len_next      = len_reg;
    cnt_next      = cnt_reg;
    incr_next     = incr_reg;
    rsp_data_next = rsp_data_reg;
    case (state_reg)
      IDLE: begin
        if (bus.cmd_valid) begin
          addr_next  = bus.cmd_addr;
          data_next  = bus.cmd_data;
          len_next   = bus.cmd_len;
          incr_next  = bus.cmd_incr;
          cnt_next   = '0;
          state_next = bus.cmd_write ? WR : RD_ISSUE;
        end
      end
      WR: begin
        addr_next = addr_reg + 7'd1;
        data_next = data_reg + {7'd0, incr_reg};
        cnt_next  = cnt_reg + 4'd1;
        if (last_beat) state_next = DONE;
      end
      RD_ISSUE: state_next = RD_WAIT;
      RD_WAIT: begin
        rsp_data_next = bus.mem_dout;
        state_next    = RD_HOLD;
      end
      RD_HOLD: begin
        if (bus.rsp_ready) begin
          if (last_beat) begin
            state_next = DONE;
          end else begin
            addr_next  = addr_reg + 7'd1;
            cnt_next   = cnt_reg + 4'd1;
            state_next = RD_ISSUE;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_last  = 1'b0;
    bus.done      = 1'b0;
    bus.mem_ren   = 1'b0;
    bus.mem_wen   = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_din   = '0;
    case (state_reg)
      IDLE: bus.cmd_ready = 1'b1;
      WR: begin
        bus.mem_wen  = 1'b1;
        bus.mem_addr = addr_reg;
        bus.mem_din  = data_reg;
      end
      RD_ISSUE: begin
        bus.mem_ren  = 1'b1;
        bus.mem_addr = addr_reg;
      end
      RD_HOLD: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_last  = last_beat;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.rsp_data = rsp_data_reg;

endmodule

// File: tb/tb_mem_burst_master.sv
// Self-checking bench for mem_burst_master: directed table, reset abort, and
// random bursts checked against a word-level scoreboard of memory contents.
module tb_mem_burst_master;
  logic clk;
  logic rst;
  mem_burst_master_if bus ();

  mem_burst_master dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory attached to the port: registered read, 0 when not read.
  logic [7:0] tb_mem  [128];
  logic [7:0] ref_mem [128];
  always @(posedge clk) begin
    if (bus.mem_wen) tb_mem[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= bus.mem_ren ? tb_mem[bus.mem_addr] : 8'd0;
  end

  int tests;
  int failed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Always-true properties, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      tests++;
      if (bus.mem_ren && bus.mem_wen) begin
        failed++;
        $display("FAIL inv_strobes: ren=%0b wen=%0b both set", bus.mem_ren, bus.mem_wen);
      end
      if (bus.cmd_ready && (bus.mem_ren || bus.mem_wen || bus.done || bus.rsp_valid)) begin
        failed++;
        $display("FAIL inv_idle: cmd_ready with ren=%0b wen=%0b done=%0b rsp_valid=%0b, expected all 0",
                 bus.mem_ren, bus.mem_wen, bus.done, bus.rsp_valid);
      end
      if (!bus.mem_ren && !bus.mem_wen && (bus.mem_addr != 7'd0 || bus.mem_din != 8'd0)) begin
        failed++;
        $display("FAIL inv_idle_bus: addr=0x%0h din=0x%0h, expected 0", bus.mem_addr, bus.mem_din);
      end
    end
  end

  // Advance one cycle; cmd_* and rsp_ready get noise that the DUT must ignore.
  task automatic step();
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'($urandom_range(0, 1));
    bus.cmd_write = 1'($urandom_range(0, 1));
    bus.cmd_incr  = 1'($urandom_range(0, 1));
    bus.cmd_addr  = 7'($urandom);
    bus.cmd_len   = 4'($urandom);
    bus.cmd_data  = 8'($urandom);
    bus.rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic check_reset_outputs();
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data",  bus.rsp_data,  0);
    check("rst_rsp_last",  bus.rsp_last,  0);
    check("rst_done",      bus.done,      0);
    check("rst_mem_ren",   bus.mem_ren,   0);
    check("rst_mem_wen",   bus.mem_wen,   0);
    check("rst_mem_addr",  bus.mem_addr,  0);
    check("rst_mem_din",   bus.mem_din,   0);
  endtask

  // One command; stall<0 picks a random stall per read beat; abort_beat>=0 pulses rst in that write beat.
  task automatic run_cmd(input logic wr, input logic inc, input logic [6:0] a, input logic [3:0] n,
                         input logic [7:0] d, input int stall, input int abort_beat,
                         output logic [7:0] first, output logic [7:0] last);
    int wait_n;
    int s;
    logic [7:0] v;
    logic [6:0] idx;
    wait_n = 0;
    first  = 8'd0;
    last   = 8'd0;
    bus.cmd_valid = 1'b0;
    while (!bus.cmd_ready && wait_n < 20) begin
      step();
      bus.cmd_valid = 1'b0;
      wait_n++;
    end
    check("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_incr  = inc;
    bus.cmd_addr  = a;
    bus.cmd_len   = n;
    bus.cmd_data  = d;
    step();
    if (wr) begin
      for (int i = 0; i <= int'(n); i++) begin
        idx = 7'(int'(a) + i);
        v   = inc ? 8'(int'(d) + i) : d;
        check("wr_wen",  bus.mem_wen,  1);
        check("wr_ren",  bus.mem_ren,  0);
        check("wr_addr", bus.mem_addr, idx);
        check("wr_din",  bus.mem_din,  v);
        ref_mem[idx] = v;
        if (i == 0) first = bus.mem_din;
        last = bus.mem_din;
        if (i == abort_beat) begin
          rst = 1'b1;
          step();
          bus.cmd_valid = 1'b0;
          rst = 1'b0;
          check_reset_outputs();
          step();
          bus.cmd_valid = 1'b0;
          check("abort_no_done", bus.done, 0);
          return;
        end
        step();
      end
    end else begin
      for (int i = 0; i <= int'(n); i++) begin
        idx = 7'(int'(a) + i);
        v   = ref_mem[idx];
        check("rd_issue_ren",  bus.mem_ren,  1);
        check("rd_issue_addr", bus.mem_addr, idx);
        step();
        check("rd_wait_ren",   bus.mem_ren,   0);
        check("rd_wait_valid", bus.rsp_valid, 0);
        step();
        s = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
        for (int k = 0; k < s; k++) begin
          bus.rsp_ready = 1'b0;
          check("rd_stall_valid", bus.rsp_valid, 1);
          check("rd_stall_data",  bus.rsp_data,  v);
          step();
          check("rd_stall_no_ren", bus.mem_ren, 0);
        end
        check("rd_valid", bus.rsp_valid, 1);
        check("rd_data",  bus.rsp_data,  v);
        check("rd_last",  bus.rsp_last,  (i == int'(n)) ? 1 : 0);
        if (i == 0) first = bus.rsp_data;
        last = bus.rsp_data;
        bus.rsp_ready = 1'b1;
        step();
      end
    end
    check("done_pulse", bus.done, 1);
    check("done_ren",   bus.mem_ren, 0);
    check("done_wen",   bus.mem_wen, 0);
    step();
    bus.cmd_valid = 1'b0;
    check("done_one_cycle", bus.done, 0);
    check("back_idle", bus.cmd_ready, 1);
  endtask

  typedef struct {
    logic       wr;
    logic       inc;
    logic [6:0] addr;
    logic [3:0] len;
    logic [7:0] data;
    int         stall;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [6];
    logic [7:0] f;
    logic [7:0] l;
    tests  = 0;
    failed = 0;
    for (int i = 0; i < 128; i++) begin
      tb_mem[i]  = 8'($urandom);
      ref_mem[i] = tb_mem[i];
    end
    tbl[0] = '{1'b1, 1'b1, 7'h10, 4'd3, 8'hA0, 0,  8'hA0, 8'hA3};
    tbl[1] = '{1'b0, 1'b0, 7'h10, 4'd3, 8'h00, 0,  8'hA0, 8'hA3};
    tbl[2] = '{1'b1, 1'b0, 7'h7E, 4'd3, 8'h55, 0,  8'h55, 8'h55};
    tbl[3] = '{1'b0, 1'b0, 7'h7E, 4'd3, 8'h00, 1,  8'h55, 8'h55};
    tbl[4] = '{1'b0, 1'b0, 7'h11, 4'd1, 8'h00, 5,  8'hA1, 8'hA2};
    tbl[5] = '{1'b1, 1'b1, 7'h70, 4'd15, 8'hF8, 0, 8'hF8, 8'h07};

    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_incr  = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;

    for (int t = 0; t < 6; t++) begin
      run_cmd(tbl[t].wr, tbl[t].inc, tbl[t].addr, tbl[t].len, tbl[t].data, tbl[t].stall, -1, f, l);
      check($sformatf("vec%0d_first", t), f, tbl[t].exp_first);
      check($sformatf("vec%0d_last", t),  l, tbl[t].exp_last);
      $display("[TB] vec %0d wr=%0b addr=0x%02h len=%0d first=0x%02h last=0x%02h",
               t, tbl[t].wr, tbl[t].addr, tbl[t].len, f, l);
    end

    // Reset in the third beat of an 8-beat write: beats 0-2 stay in memory.
    run_cmd(1'b1, 1'b1, 7'h40, 4'd7, 8'h30, 0, 2, f, l);
    $display("[TB] abort write at beat 2 addr=0x40");
    run_cmd(1'b0, 1'b0, 7'h40, 4'd3, 8'h00, 0, -1, f, l);
    check("abort_kept_first", f, 8'h30);
    $display("[TB] readback after abort first=0x%02h last=0x%02h", f, l);

    for (int r = 0; r < 40; r++) begin
      logic       wr;
      logic       inc;
      logic [6:0] a;
      logic [3:0] n;
      logic [7:0] d;
      wr  = 1'($urandom_range(0, 1));
      inc = 1'($urandom_range(0, 1));
      a   = (r % 5 == 0) ? 7'(7'h7C + 7'($urandom_range(0, 3))) : 7'($urandom);
      n   = 4'($urandom);
      d   = 8'($urandom);
      run_cmd(wr, inc, a, n, d, -1, -1, f, l);
      $display("[TB] rand %0d wr=%0b incr=%0b addr=0x%02h len=%0d first=0x%02h last=0x%02h",
               r, wr, inc, a, n, f, l);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/mem_burst_master.md
MEM_BURST_MASTER -- requirements
Module: mem_burst_master

Interface
REQ-001 Parameters: none; memory geometry is fixed at 128 words x 8 bits, 7-bit address, 4-bit burst length field.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  block accepts command this cycle.
REQ-006 cmd_write  input  1  1 = burst write (fill), 0 = burst read.
REQ-007 cmd_incr  input  1  write only: 1 = data pattern increments per beat, 0 = constant.
REQ-008 cmd_addr  input  7  start address.
REQ-009 cmd_len  input  4  beats minus one (0 -> 1 beat, 15 -> 16 beats).
REQ-010 cmd_data  input  8  write seed value.
REQ-011 rsp_valid  output  1  read beat available on rsp_data.
REQ-012 rsp_ready  input  1  consumer takes read beat.
REQ-013 rsp_data  output  8  read beat value.
REQ-014 rsp_last  output  1  qualifies final read beat of burst.
REQ-015 done  output  1  one-cycle pulse when any command completes.
REQ-016 mem_ren, mem_wen  output  1 each  memory port strobes.
REQ-017 mem_addr  output  7;  mem_din  output  8;  mem_dout  input  8 (registered, valid the cycle after mem_ren sampled high, 0 otherwise).

Function
REQ-018 FSM states SHALL be IDLE, WR, RD_ISSUE, RD_WAIT, RD_HOLD, DONE.
REQ-019 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a cycle with cmd_valid && cmd_ready, latching addr, len, data, write, incr.
REQ-020 IDLE -> WR on accepted write; IDLE -> RD_ISSUE on accepted read.
REQ-021 WR: mem_wen=1, mem_ren=0, mem_addr=current address, mem_din=current data; one beat per cycle, no stalls.
REQ-022 Per write beat: address += 1 modulo 128; data += 1 modulo 256 if incr, else unchanged; beat counter += 1.
REQ-023 WR -> DONE after beat len+1 is issued.
REQ-024 RD_ISSUE: mem_ren=1, mem_wen=0, mem_addr=current address, for exactly one cycle; -> RD_WAIT.
REQ-025 RD_WAIT: mem_ren=0; rsp_data register captures mem_dout at end of cycle; -> RD_HOLD.
REQ-026 RD_HOLD: rsp_valid=1, rsp_data stable, rsp_last=1 iff beat counter == len; hold until rsp_ready.
REQ-027 On rsp_valid && rsp_ready: if last -> DONE, else address += 1 modulo 128, counter += 1, -> RD_ISSUE.
REQ-028 Read burst throughput: 3 cycles per beat minimum; first rsp_valid 3 cycles after acceptance edge.
REQ-029 Address wrap 127 -> 0 SHALL occur silently inside a burst in both directions.
REQ-030 DONE: done=1 for one cycle, all strobes 0; -> IDLE.
REQ-031 mem_ren and mem_wen SHALL never both be 1; outside WR/RD_ISSUE both are 0, mem_addr and mem_din are 0.
REQ-032 cmd_* inputs SHALL be ignored outside IDLE; rsp_ready SHALL be ignored outside RD_HOLD.
REQ-033 Write fill of len=15 SHALL complete in 16 WR cycles plus 1 DONE cycle.

Reset
REQ-034 rst sampled high SHALL force IDLE on the same edge, regardless of state, including mid-burst; the burst is abandoned with no done pulse.
REQ-035 Reset values: cmd_ready=1 (IDLE), rsp_valid=0, rsp_data=0, rsp_last=0, done=0, mem_ren=0, mem_wen=0, mem_addr=0, mem_din=0; internal counters, address, and data registers=0.
REQ-036 Memory contents are not cleared by rst; words already written remain.

Verification
REQ-037 Write addr=0x10, len=3, data=0xA0, incr=1 -> mem_wen high 4 cycles, addresses 0x10..0x13, data A0,A1,A2,A3; done one cycle later.
REQ-038 Read addr=0x10, len=3, rsp_ready=1 -> rsp_data A0,A1,A2,A3, rsp_last only on A3, first rsp_valid 3 cycles after accept.
REQ-039 Write addr=0x7E, len=3, data=0x55, incr=0 -> addresses 7E,7F,00,01 all 0x55; read back the same range with wrap.
REQ-040 Read len=1 with rsp_ready low for 5 cycles in RD_HOLD -> rsp_valid and rsp_data held stable; no new mem_ren until handshake.
REQ-041 Assert rst during the 3rd beat of a len=7 write -> next cycle IDLE, all outputs at reset values, no done; beats 0-2 remain in memory.
REQ-042 Every cycle assertion: !(mem_ren && mem_wen); cmd_ready == (state == IDLE).
